// File: rtl/adc_pkg.sv
// Shared widths, modes and packed-stream geometry for the ADC sample packer slice.
package adc_pkg;
  localparam int SAMPLE_W    = 10;
  localparam int WORD_W      = 20;
  localparam int PACK_W      = 8;
  localparam int PACK_PHASES = 5;
  localparam int PAIR_W      = 2 * PACK_W;
  localparam int ACC_W       = 2 * PAIR_W;
  localparam int PHASE_W     = $clog2(PACK_PHASES);
  localparam int SHIFT_W     = $clog2(ACC_W);

  typedef enum logic {MODE_10B = 1'b0, MODE_8B = 1'b1} mode_t;

  // Stream bits already held from earlier pairs when a phase begins.
  function automatic logic [SHIFT_W-1:0] carry_bits(input logic [PHASE_W-1:0] phase);
    case (phase)
      3'd1:    carry_bits = 5'd16;
      3'd2:    carry_bits = 5'd12;
      3'd3:    carry_bits = 5'd8;
      3'd4:    carry_bits = 5'd4;
      default: carry_bits = 5'd0;
    endcase
  endfunction
endpackage

// File: rtl/adc_sample_packer_if.sv
// Pin bundle between ADC/control sources, the packer and the FIFO write port.
// Latency: none (wiring only). Backpressure: fifo_full only; the ADC side never stalls.
// test_mode exists only when ADC_PACKER_TEST_PATTERN_EN is defined.
interface adc_sample_packer_if #(
  parameter int DROP_CNT_W = 16
);
  import adc_pkg::*;

  logic                  enable;
  logic                  pack8;
  logic                  clr_overflow;
  logic [SAMPLE_W-1:0]   adc0_data;
  logic [SAMPLE_W-1:0]   adc1_data;
  logic                  fifo_full;
  logic [WORD_W-1:0]     fifo_wdata;
  logic                  fifo_winc;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_count;
`ifdef ADC_PACKER_TEST_PATTERN_EN
  logic                  test_mode;
`endif

  modport master (
`ifdef ADC_PACKER_TEST_PATTERN_EN
    output test_mode,
`endif
    output enable, pack8, clr_overflow, adc0_data, adc1_data, fifo_full,
    input  fifo_wdata, fifo_winc, overflow, drop_count
  );

  modport slave (
`ifdef ADC_PACKER_TEST_PATTERN_EN
    input  test_mode,
`endif
    input  enable, pack8, clr_overflow, adc0_data, adc1_data, fifo_full,
    output fifo_wdata, fifo_winc, overflow, drop_count
  );
endinterface

// File: rtl/pack8_gearbox.sv
// 16-bit pair to 20-bit word gearbox: 5 pairs in, 4 words out, MSB-first stream.
// Latency: combinational word/valid from the current pair; phase advances per pair.
// Backpressure: none; dropping pair_vld_i discards the partial group and restarts at phase 0.
module pack8_gearbox
  import adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pair_vld_i,
  input  logic [PAIR_W-1:0] pair_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o
);
  localparam logic [PHASE_W-1:0] PH_FIRST = '0;
  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(PACK_PHASES - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   merged;

  // acc_q keeps leftover stream bits left-aligned; the new pair lands right behind them.
  always_comb begin
    merged     = acc_q | ({pair_i, {PAIR_W{1'b0}}} >> carry_bits(phase_q));
    word_o     = merged[ACC_W-1 -: WORD_W];
    word_vld_o = pair_vld_i && (phase_q != PH_FIRST);
    phase_d    = PH_FIRST;
    acc_d      = '0;
    if (pair_vld_i) begin
      phase_d = (phase_q == PH_LAST) ? PH_FIRST : phase_q + 1'b1;
      acc_d   = (phase_q == PH_FIRST) ? merged : (merged << WORD_W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_FIRST;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: rtl/sync_cell.sv
// Level synchroniser: shift chain bringing an asynchronous bit into clk.
// Latency: STAGES clk. Backpressure: none.
// Output clears to 0 on rst.
module sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/adc_sample_packer.sv
// ADC write-side front end: registers both samples, formats 10-bit or packed 8-bit FIFO words.
// Latency: 2 clk pin to fifo_wdata/fifo_winc. Optional test pattern: ADC_PACKER_TEST_PATTERN_EN.
// Backpressure: none upstream; writes during fifo_full are dropped, counted and flagged.
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int DROP_CNT_W  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  adc_sample_packer_if.slave bus
);
  logic en_s, pk_s;

  sync_cell #(.STAGES(SYNC_STAGES)) u_sync_en (.clk(clk), .rst(rst), .d_i(bus.enable), .q_o(en_s));
  sync_cell #(.STAGES(SYNC_STAGES)) u_sync_pk (.clk(clk), .rst(rst), .d_i(bus.pack8),  .q_o(pk_s));

  logic [SAMPLE_W-1:0] adc0_q, adc1_q, adc0_d, adc1_d;

`ifdef ADC_PACKER_TEST_PATTERN_EN
  logic                tm_s;
  logic [SAMPLE_W-1:0] pat_q;

  sync_cell #(.STAGES(SYNC_STAGES)) u_sync_tm (.clk(clk), .rst(rst), .d_i(bus.test_mode), .q_o(tm_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pat_q <= '0;
    else     pat_q <= pat_q + 1'b1;
  end

  assign adc0_d = tm_s ? pat_q  : bus.adc0_data;
  assign adc1_d = tm_s ? ~pat_q : bus.adc1_data;
`else
  assign adc0_d = bus.adc0_data;
  assign adc1_d = bus.adc1_data;
`endif

  mode_t mode_q, mode_d;
  assign mode_d = en_s ? mode_q : (pk_s ? MODE_8B : MODE_10B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc0_q <= '0;
      adc1_q <= '0;
      mode_q <= MODE_10B;
    end else begin
      adc0_q <= adc0_d;
      adc1_q <= adc1_d;
      mode_q <= mode_d;
    end
  end

  logic              gb_vld;
  logic [WORD_W-1:0] gb_word;

  pack8_gearbox u_gearbox (
    .clk       (clk),
    .rst       (rst),
    .pair_vld_i(en_s && (mode_q == MODE_8B)),
    .pair_i    ({adc0_q[SAMPLE_W-1 -: PACK_W], adc1_q[SAMPLE_W-1 -: PACK_W]}),
    .word_o    (gb_word),
    .word_vld_o(gb_vld)
  );

  logic                  cand_vld, drop;
  logic [WORD_W-1:0]     cand_word;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  winc_q, winc_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // The packing phase keeps advancing through drops, so a full FIFO never stalls the ADC.
  always_comb begin
    cand_vld   = en_s && ((mode_q == MODE_10B) || gb_vld);
    cand_word  = (mode_q == MODE_8B) ? gb_word : {adc0_q, adc1_q};
    drop       = cand_vld && bus.fifo_full;
    winc_d     = cand_vld && !bus.fifo_full;
    wdata_d    = winc_d ? cand_word : wdata_q;
    ovf_d      = drop ? 1'b1 : (bus.clr_overflow ? 1'b0 : ovf_q);
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_q    <= '0;
      winc_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wdata_q    <= wdata_d;
      winc_q     <= winc_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.fifo_wdata = wdata_q;
  assign bus.fifo_winc  = winc_q;
  assign bus.overflow   = ovf_q;
  assign bus.drop_count = drop_cnt_q;
endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: directed tables, hand sequences and a random run vs a stream model.
module tb_adc_sample_packer;
  localparam int SYNC = 2;
  localparam int DCW  = 4;
  localparam int MAXH = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_sample_packer_if #(.DROP_CNT_W(DCW)) bus ();
  adc_sample_packer #(.DROP_CNT_W(DCW), .SYNC_STAGES(SYNC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic        vld;
    logic [19:0] word;
  } vec_t;

  vec_t t10[5];
  vec_t t8[10];

  int n_chk  = 0;
  int n_pass = 0;

  // Applied-input history since the last reset, indexed by step.
  logic       en_h[MAXH];
  logic       pk_h[MAXH];
  logic [9:0] a0_h[MAXH];
  logic [9:0] a1_h[MAXH];
  logic       f_h[MAXH];
  logic       clr_h[MAXH];
  int         gi;

  logic        m_mode;
  logic [15:0] grp[$];
  logic        m_ovf;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step=%0d: got %h expected %h", name, gi, act, exp);
  endtask

  task automatic model_reset();
    gi = 0;
    m_mode = 1'b0;
    m_ovf = 1'b0;
    m_cnt = 0;
    grp.delete();
  endtask

  function automatic logic [19:0] grp_word();
    logic [79:0] s;
    s = '0;
    for (int j = 0; j < grp.size(); j++) s[79-16*j -: 16] = grp[j];
    return s[79-20*(grp.size()-2) -: 20];
  endfunction

  // Output after step i: sample applied at step i-1, full/clr of step i, enable/pack8 delayed by SYNC.
  task automatic model_check(input int i);
    int          idx;
    logic        e, p, eeff, vld;
    logic [9:0]  s0, s1;
    logic [19:0] w;
    idx  = i - 1 - SYNC;
    e    = (idx >= 0) ? en_h[idx] : 1'b0;
    p    = (idx >= 0) ? pk_h[idx] : 1'b0;
    if (!e) m_mode = p;
    eeff = (i >= SYNC) ? en_h[i-SYNC] : 1'b0;
    s0   = (i >= 1) ? a0_h[i-1] : 10'd0;
    s1   = (i >= 1) ? a1_h[i-1] : 10'd0;
    vld  = 1'b0;
    w    = '0;
    if (!eeff) grp.delete();
    else if (!m_mode) begin
      vld = 1'b1;
      w   = {s0, s1};
    end else begin
      grp.push_back({s0[9:2], s1[9:2]});
      if (grp.size() > 1) begin
        vld = 1'b1;
        w   = grp_word();
      end
      if (grp.size() == 5) grp.delete();
    end
    if (vld && f_h[i]) begin
      m_ovf = 1'b1;
      if (m_cnt < (1 << DCW) - 1) m_cnt++;
    end else if (clr_h[i]) m_ovf = 1'b0;
    chk("model_winc", bus.fifo_winc, vld && !f_h[i]);
    if (vld && !f_h[i]) chk("model_wdata", bus.fifo_wdata, w);
    chk("model_overflow", bus.overflow, m_ovf);
    chk("model_drop_count", bus.drop_count, m_cnt);
  endtask

  task automatic step(input logic en, input logic pk, input logic [9:0] a0, input logic [9:0] a1,
                      input logic f, input logic clr);
    bus.enable = en; bus.pack8 = pk; bus.adc0_data = a0; bus.adc1_data = a1;
    bus.fifo_full = f; bus.clr_overflow = clr;
    en_h[gi] = en; pk_h[gi] = pk; a0_h[gi] = a0; a1_h[gi] = a1; f_h[gi] = f; clr_h[gi] = clr;
    @(posedge clk);
    #1;
    model_check(gi);
    gi++;
  endtask

  task automatic idle(input int n, input logic en, input logic pk);
    for (int k = 0; k < n; k++) step(en, pk, 10'd0, 10'd0, 1'b0, 1'b0);
  endtask

  // Enable, feed n_apply table entries, compare each entry's output one step later.
  task automatic run_tbl(input logic is8, input int n_apply, input logic en_after);
    vec_t cur, prev;
    logic pk;
    idle(SYNC - 1, 1'b1, is8);
    prev = '{a0: 10'd0, a1: 10'd0, vld: 1'b0, word: 20'd0};
    for (int k = 0; k <= n_apply; k++) begin
      cur = '{a0: 10'd0, a1: 10'd0, vld: 1'b0, word: 20'd0};
      if (k < n_apply) begin
        if (is8) cur = t8[k];
        else     cur = t10[k];
      end
      pk = is8 && !(k == 3 || k == 4);
      step((k < n_apply) ? 1'b1 : en_after, pk, cur.a0, cur.a1, 1'b0, 1'b0);
      if (k > 0) begin
        chk(is8 ? "tbl8_winc" : "tbl10_winc", bus.fifo_winc, prev.vld);
        if (prev.vld) chk(is8 ? "tbl8_word" : "tbl10_word", bus.fifo_wdata, prev.word);
      end
      prev = cur;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] w8[5];
    logic        r_en, r_pk;
    w8 = '{20'h00000, 20'h01020, 20'h30405, 20'h06070, 20'h8090A};
    for (int i = 0; i < 4; i++) t10[i] = '{a0: 10'h155, a1: 10'h2AA, vld: 1'b1, word: 20'h556AA};
    t10[4] = '{a0: 10'h3FF, a1: 10'h001, vld: 1'b1, word: 20'hFFC01};
    for (int i = 0; i < 10; i++) begin
      int p;
      p = i % 5;
      t8[i] = '{a0: {8'(2*p+1), 2'b11}, a1: {8'(2*p+2), 2'b01}, vld: (p != 0), word: w8[p]};
    end

    rst = 1'b1;
    bus.enable = 0; bus.pack8 = 0; bus.clr_overflow = 0; bus.fifo_full = 0;
    bus.adc0_data = 0; bus.adc1_data = 0;
`ifdef ADC_PACKER_TEST_PATTERN_EN
    bus.test_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wdata", bus.fifo_wdata, 0);
    chk("reset_winc", bus.fifo_winc, 0);
    chk("reset_overflow", bus.overflow, 0);
    chk("reset_drop_count", bus.drop_count, 0);
    rst = 1'b0;
    model_reset();

    idle(4, 1'b0, 1'b0);
    run_tbl(1'b0, 5, 1'b1);

    repeat (3) step(1'b1, 1'b0, 10'h155, 10'h2AA, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'h155, 10'h2AA, 1'b0, 1'b0);
    chk("full_overflow", bus.overflow, 1);
    chk("full_drop_count", bus.drop_count, 3);
    step(1'b1, 1'b0, 10'h155, 10'h2AA, 1'b0, 1'b1);
    chk("clr_overflow", bus.overflow, 0);
    chk("clr_keeps_count", bus.drop_count, 3);

    repeat (20) step(1'b1, 1'b0, 10'h0F0, 10'h00F, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'h0F0, 10'h00F, 1'b0, 1'b0);
    chk("sat_drop_count", bus.drop_count, 15);

    idle(4, 1'b0, 1'b1);
    run_tbl(1'b1, 10, 1'b0);
    idle(4, 1'b0, 1'b1);
    run_tbl(1'b1, 2, 1'b0);
    idle(4, 1'b0, 1'b1);
    run_tbl(1'b1, 10, 1'b1);

    #3;
    rst = 1'b1;
    #1;
    chk("arst_wdata", bus.fifo_wdata, 0);
    chk("arst_winc", bus.fifo_winc, 0);
    chk("arst_overflow", bus.overflow, 0);
    chk("arst_drop_count", bus.drop_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    r_en = 1'b1;
    r_pk = 1'b1;
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(39) == 0) r_en = !r_en;
      if ($urandom_range(9) == 0)  r_pk = !r_pk;
      step(r_en, r_pk, 10'($urandom), 10'($urandom), $urandom_range(3) == 0, $urandom_range(29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
